// File: rtl/loop_activity_monitor.sv
// Passive performance monitor for an HLS block and its pipelined loop.
// Counts runs, run latency, loop iterations and stalls; freezes the counters on the first finish.
module loop_activity_monitor #(
    parameter int STATE_W = 1,
    parameter int CNT_W   = 32
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ap_start,
    input  logic               ap_ready,
    input  logic               ap_done,
    input  logic               ap_continue,
    input  logic [STATE_W-1:0] cur_state,
    input  logic [STATE_W-1:0] iter_start_state,
    input  logic [STATE_W-1:0] iter_end_state,
    input  logic               iter_start_block,
    input  logic               iter_end_block,
    input  logic               iter_start_enable,
    input  logic               iter_end_enable,
    input  logic               loop_done,
    input  logic               finish,
    output logic               busy,
    output logic [CNT_W-1:0]   run_count,
    output logic [CNT_W-1:0]   last_latency,
    output logic [CNT_W-1:0]   iter_started,
    output logic [CNT_W-1:0]   iter_completed,
    output logic [CNT_W-1:0]   in_flight,
    output logic [CNT_W-1:0]   stall_cycles,
    output logic               report_valid
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] C_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] C_ONE = CNT_W'(1);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == C_MAX) ? v : v + C_ONE;
    endfunction

    state_t           r_state;
    logic [CNT_W-1:0] r_lat;
    logic             r_busy;
    logic [CNT_W-1:0] r_run_count;
    logic [CNT_W-1:0] r_last_latency;
    logic [CNT_W-1:0] r_iter_started;
    logic [CNT_W-1:0] r_iter_completed;
    logic [CNT_W-1:0] r_in_flight;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             r_frozen;

    logic             w_active;
    logic             w_gate;
    logic             w_start_hit;
    logic             w_end_hit;
    logic             w_start_ev;
    logic             w_end_ev;
    logic             w_stall;
    logic             w_complete;
    logic [CNT_W-1:0] w_lat_next;
    logic             w_unused;

    assign w_active    = (r_state != S_IDLE);
    assign w_gate      = w_active | ap_start;
    assign w_start_hit = (cur_state == iter_start_state);
    assign w_end_hit   = (cur_state == iter_end_state);
    assign w_start_ev  = w_gate & w_start_hit & iter_start_enable & ~iter_start_block;
    assign w_end_ev    = w_gate & w_end_hit & iter_end_enable & ~iter_end_block;
    assign w_stall     = w_active & (iter_start_block | iter_end_block) & (w_start_hit | w_end_hit);
    assign w_complete  = ((r_state == S_RUN) & ap_done & ap_continue) |
                         ((r_state == S_HOLD) & ap_continue);
    // The latency counter only advances while running; it is parked during HOLD.
    assign w_lat_next  = (r_state == S_RUN) ? sat_inc(r_lat) : r_lat;
    assign w_unused    = &{1'b0, ap_ready, loop_done};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state        <= S_IDLE;
            r_lat          <= '0;
            r_busy         <= 1'b0;
            r_run_count    <= '0;
            r_last_latency <= '0;
        end else begin
            r_busy <= w_active;
            case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_state <= S_RUN;
                        r_lat   <= C_ONE;
                    end
                end
                S_RUN, S_HOLD: begin
                    if (w_complete) begin
                        if (!r_frozen) begin
                            r_run_count    <= sat_inc(r_run_count);
                            r_last_latency <= w_lat_next;
                        end
                        if (ap_start) begin
                            r_state <= S_RUN;
                            r_lat   <= C_ONE;
                        end else begin
                            r_state <= S_IDLE;
                            r_lat   <= w_lat_next;
                        end
                    end else if ((r_state == S_RUN) && ap_done) begin
                        r_state <= S_HOLD;
                        r_lat   <= w_lat_next;
                    end else begin
                        r_lat <= w_lat_next;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // The finish edge still updates the counters; only later edges are frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_iter_started   <= '0;
            r_iter_completed <= '0;
            r_in_flight      <= '0;
            r_stall_cycles   <= '0;
            r_frozen         <= 1'b0;
        end else begin
            if (finish) begin
                r_frozen <= 1'b1;
            end
            if (!r_frozen) begin
                if (w_start_ev) begin
                    r_iter_started <= sat_inc(r_iter_started);
                end
                if (w_end_ev) begin
                    r_iter_completed <= sat_inc(r_iter_completed);
                end
                if (w_start_ev && !w_end_ev) begin
                    r_in_flight <= sat_inc(r_in_flight);
                end else if (!w_start_ev && w_end_ev && (r_in_flight != '0)) begin
                    r_in_flight <= r_in_flight - C_ONE;
                end
                if (w_stall) begin
                    r_stall_cycles <= sat_inc(r_stall_cycles);
                end
            end
        end
    end

    assign busy           = r_busy;
    assign run_count      = r_run_count;
    assign last_latency   = r_last_latency;
    assign iter_started   = r_iter_started;
    assign iter_completed = r_iter_completed;
    assign in_flight      = r_in_flight;
    assign stall_cycles   = r_stall_cycles;
    assign report_valid   = r_frozen;

endmodule

// File: tb/tb_loop_activity_monitor.sv
// Bench for loop_activity_monitor: directed scenarios plus random traffic, every cycle
// checked against an integer reference model through an expected-value queue.
module tb_loop_activity_monitor;
  localparam int STATE_W = 2;
  localparam int CNT_W   = 4;
  localparam int MAXV    = (1 << CNT_W) - 1;
  localparam int W       = 2 + 6 * CNT_W;

  // clock / reset block
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic ap_start = 1'b0, ap_ready = 1'b0, ap_done = 1'b0, ap_continue = 1'b1;
  logic [STATE_W-1:0] cur_state = '0, iter_start_state = '0, iter_end_state = '0;
  logic iter_start_block = 1'b0, iter_end_block = 1'b0;
  logic iter_start_enable = 1'b0, iter_end_enable = 1'b0;
  logic loop_done = 1'b0, finish = 1'b0;

  logic busy, report_valid;
  logic [CNT_W-1:0] run_count, last_latency, iter_started, iter_completed, in_flight, stall_cycles;

  loop_activity_monitor #(.STATE_W(STATE_W), .CNT_W(CNT_W)) dut (
    .clock(clock), .reset(reset),
    .ap_start(ap_start), .ap_ready(ap_ready), .ap_done(ap_done), .ap_continue(ap_continue),
    .cur_state(cur_state), .iter_start_state(iter_start_state), .iter_end_state(iter_end_state),
    .iter_start_block(iter_start_block), .iter_end_block(iter_end_block),
    .iter_start_enable(iter_start_enable), .iter_end_enable(iter_end_enable),
    .loop_done(loop_done), .finish(finish),
    .busy(busy), .run_count(run_count), .last_latency(last_latency),
    .iter_started(iter_started), .iter_completed(iter_completed),
    .in_flight(in_flight), .stall_cycles(stall_cycles), .report_valid(report_valid)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [W-1:0] exp_q[$];

  // reference model: plain integers and flags
  bit m_running, m_holding, m_busy, m_frozen;
  int m_lat, m_runs, m_last, m_started, m_completed, m_pending, m_stall;

  function automatic int sat(input int v);
    return (v > MAXV) ? MAXV : v;
  endfunction

  task automatic model_step();
    bit active, gate, s_ev, e_ev, st, done_now;
    int lat_now, p;
    if (!reset) begin
      m_running = 0; m_holding = 0; m_busy = 0; m_frozen = 0;
      m_lat = 0; m_runs = 0; m_last = 0; m_started = 0; m_completed = 0; m_pending = 0; m_stall = 0;
      return;
    end
    active   = m_running || m_holding;
    gate     = active || ap_start;
    s_ev     = gate && (cur_state == iter_start_state) && iter_start_enable && !iter_start_block;
    e_ev     = gate && (cur_state == iter_end_state) && iter_end_enable && !iter_end_block;
    st       = active && (iter_start_block || iter_end_block) &&
               ((cur_state == iter_start_state) || (cur_state == iter_end_state));
    lat_now  = m_running ? sat(m_lat + 1) : m_lat;
    done_now = (m_running && ap_done && ap_continue) || (m_holding && ap_continue);
    if (!m_frozen) begin
      if (done_now) begin
        m_runs = sat(m_runs + 1);
        m_last = lat_now;
      end
      if (s_ev) m_started = sat(m_started + 1);
      if (e_ev) m_completed = sat(m_completed + 1);
      p = m_pending + int'(s_ev) - int'(e_ev);
      m_pending = (p < 0) ? 0 : sat(p);
      if (st) m_stall = sat(m_stall + 1);
    end
    if (finish) m_frozen = 1;
    m_busy = active;
    if (!active) begin
      if (ap_start) begin m_running = 1; m_lat = 1; end
    end else if (done_now) begin
      m_holding = 0;
      m_running = ap_start;
      m_lat = ap_start ? 1 : lat_now;
    end else if (m_running && ap_done) begin
      m_running = 0; m_holding = 1; m_lat = lat_now;
    end else begin
      m_lat = lat_now;
    end
  endtask

  // driver: inputs are set just after a falling edge; tick models the coming rising edge
  task automatic tick();
    model_step();
    exp_q.push_back({m_busy, m_frozen, CNT_W'(m_runs), CNT_W'(m_last), CNT_W'(m_started),
                     CNT_W'(m_completed), CNT_W'(m_pending), CNT_W'(m_stall)});
    @(negedge clock);
  endtask

  task automatic cmp(input string name, input logic [CNT_W-1:0] act, input logic [CNT_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    ap_start = 0; ap_ready = 0; ap_done = 0; ap_continue = 1; finish = 0; loop_done = 0;
    cur_state = '0; iter_start_state = '0; iter_end_state = '0;
    iter_start_block = 0; iter_end_block = 0; iter_start_enable = 0; iter_end_enable = 0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 0;
    tick();
    reset = 1;
  endtask

  // scoreboard monitor: pops one expectation per rising edge, samples 1 time unit later
  always @(posedge clock) begin
    logic [W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      cmp("busy", CNT_W'(busy), CNT_W'(e[W-1]));
      cmp("report_valid", CNT_W'(report_valid), CNT_W'(e[W-2]));
      cmp("run_count", run_count, e[6*CNT_W-1 -: CNT_W]);
      cmp("last_latency", last_latency, e[5*CNT_W-1 -: CNT_W]);
      cmp("iter_started", iter_started, e[4*CNT_W-1 -: CNT_W]);
      cmp("iter_completed", iter_completed, e[3*CNT_W-1 -: CNT_W]);
      cmp("in_flight", in_flight, e[2*CNT_W-1 -: CNT_W]);
      cmp("stall_cycles", stall_cycles, e[CNT_W-1:0]);
    end
  end

  initial begin
    clear_inputs();
    reset = 0;
    @(negedge clock);
    tick(); tick();
    reset = 1;

    // reset mid-run, then a fresh run of 5 cycles
    ap_start = 1; tick();
    ap_start = 0; tick(); tick(); tick();
    reset = 0;
    #1;
    cmp("rst_now_busy", CNT_W'(busy), CNT_W'(0));
    cmp("rst_now_run_count", run_count, CNT_W'(0));
    cmp("rst_now_report_valid", CNT_W'(report_valid), CNT_W'(0));
    tick(); tick();
    reset = 1;
    ap_start = 1; tick();
    ap_start = 0; tick(); tick(); tick();
    ap_done = 1; tick();
    ap_done = 0; tick(); tick();
    cmp("rst_fresh_run_count", run_count, CNT_W'(1));
    cmp("rst_fresh_latency", last_latency, CNT_W'(5));

    // single run: start at cycle 0, done at cycle 9
    do_reset();
    ap_start = 1; tick();
    ap_start = 0;
    repeat (8) tick();
    ap_done = 1; tick();
    ap_done = 0; tick();
    cmp("single_busy_c11", CNT_W'(busy), CNT_W'(0));
    cmp("single_run_count", run_count, CNT_W'(1));
    cmp("single_latency", last_latency, CNT_W'(10));

    // back-to-back runs
    do_reset();
    ap_start = 1; tick();
    ap_start = 0; tick(); tick(); tick();
    ap_done = 1; ap_start = 1; tick();
    ap_done = 0; ap_start = 0;
    cmp("b2b_run_count1", run_count, CNT_W'(1));
    tick();
    cmp("b2b_busy", CNT_W'(busy), CNT_W'(1));
    tick(); tick();
    ap_done = 1; tick();
    ap_done = 0; tick();
    cmp("b2b_run_count2", run_count, CNT_W'(2));
    cmp("b2b_latency2", last_latency, CNT_W'(5));

    // continue hold: done at cycle 6, continue withheld for 4 cycles
    do_reset();
    ap_start = 1; tick();
    ap_start = 0;
    repeat (5) tick();
    ap_done = 1; ap_continue = 0;
    repeat (4) tick();
    cmp("hold_busy", CNT_W'(busy), CNT_W'(1));
    cmp("hold_run_count", run_count, CNT_W'(0));
    ap_continue = 1; tick();
    ap_done = 0; tick();
    cmp("hold_run_count_after", run_count, CNT_W'(1));
    cmp("hold_latency", last_latency, CNT_W'(7));

    // pipeline depth 3 on a single state
    do_reset();
    for (int i = 0; i < 11; i++) begin
      ap_start = (i == 0);
      iter_start_enable = (i < 8);
      iter_end_enable = (i >= 3);
      tick();
      if (i == 5) cmp("pipe_in_flight_peak", in_flight, CNT_W'(3));
    end
    ap_start = 0; iter_end_enable = 0;
    cmp("pipe_started", iter_started, CNT_W'(8));
    cmp("pipe_completed", iter_completed, CNT_W'(8));
    iter_start_enable = 1; iter_start_block = 1;
    tick(); tick();
    iter_start_enable = 0; iter_start_block = 0;
    tick();
    cmp("pipe_stall", stall_cycles, CNT_W'(2));
    cmp("pipe_started_after_stall", iter_started, CNT_W'(8));
    ap_done = 1; tick();
    ap_done = 0; tick();

    // randomized traffic
    do_reset();
    for (int i = 0; i < 700; i++) begin
      reset             = ($urandom_range(0, 119) != 0);
      ap_start          = ($urandom_range(0, 7) == 0);
      ap_ready          = $urandom_range(0, 1);
      ap_done           = ($urandom_range(0, 5) == 0);
      ap_continue       = ($urandom_range(0, 3) != 0);
      cur_state         = STATE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) iter_start_state = STATE_W'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) iter_end_state = STATE_W'($urandom_range(0, 3));
      iter_start_block  = ($urandom_range(0, 3) == 0);
      iter_end_block    = ($urandom_range(0, 3) == 0);
      iter_start_enable = $urandom_range(0, 1);
      iter_end_enable   = $urandom_range(0, 1);
      loop_done         = $urandom_range(0, 1);
      finish            = ($urandom_range(0, 149) == 0);
      tick();
    end
    reset = 1;

    // saturation and finish
    do_reset();
    ap_start = 1; iter_start_enable = 1; tick();
    ap_start = 0;
    repeat (19) tick();
    cmp("sat_started", iter_started, CNT_W'(15));
    cmp("sat_in_flight", in_flight, CNT_W'(15));
    iter_start_enable = 0;
    finish = 1; tick();
    finish = 0;
    cmp("fin_report_valid", CNT_W'(report_valid), CNT_W'(1));
    iter_end_enable = 1;
    repeat (3) tick();
    iter_end_enable = 0; iter_start_block = 1; iter_start_enable = 1;
    repeat (2) tick();
    finish = 1; tick();
    finish = 0; iter_start_block = 0; iter_start_enable = 0;
    ap_done = 1; tick();
    ap_done = 0; tick();
    cmp("fin_started", iter_started, CNT_W'(15));
    cmp("fin_completed", iter_completed, CNT_W'(0));
    cmp("fin_stall", stall_cycles, CNT_W'(0));
    cmp("fin_run_count", run_count, CNT_W'(0));
    cmp("fin_report_valid_hold", CNT_W'(report_valid), CNT_W'(1));

    clear_inputs();
    tick(); tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/loop_activity_monitor.md
Name: loop_activity_monitor

Overview:
- Synthesizable, passive performance monitor for one HLS-generated sub-module and the pipelined loop inside it.
- Observes the block-level handshake (ap_start/ap_ready/ap_done/ap_continue) and the loop FSM state, block and enable signals.
- Produces run, iteration, stall and latency counters that an external reader samples once `finish` is seen.
- Sits beside the monitored instance, taps its signals read-only, and never drives the monitored logic.

Parameters:
- STATE_W, 1, width of the monitored FSM state vector and the state-match inputs.
- CNT_W, 32, width of every counter output.

Ports:
- clock  in  1  sampling clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- ap_start  in  1  module start request.
- ap_ready  in  1  module accepts its inputs.
- ap_done  in  1  module completion.
- ap_continue  in  1  downstream accepts completion; tie high when unused.
- cur_state  in  STATE_W  current loop FSM state.
- iter_start_state  in  STATE_W  state in which an iteration starts.
- iter_end_state  in  STATE_W  state in which an iteration ends.
- iter_start_block  in  1  stall on the start state.
- iter_end_block  in  1  stall on the end state.
- iter_start_enable  in  1  first pipeline stage valid.
- iter_end_enable  in  1  last pipeline stage valid.
- loop_done  in  1  loop-internal done.
- finish  in  1  end-of-test request.
- busy  out  1  module run in progress.
- run_count  out  CNT_W  completed module runs.
- last_latency  out  CNT_W  cycles of the most recent run.
- iter_started  out  CNT_W  iterations started.
- iter_completed  out  CNT_W  iterations completed.
- in_flight  out  CNT_W  iter_started minus iter_completed.
- stall_cycles  out  CNT_W  blocked cycles while running.
- report_valid  out  1  counters frozen and stable.

Behaviour:
- Reset (reset=0, asynchronous): every output and internal register is 0; the state machine is IDLE. Releasing reset mid-run discards all partial counts.

Module state machine (IDLE, RUN, HOLD):
- IDLE->RUN on ap_start=1.
  - The latency counter loads 1 in the same edge.
- RUN: the latency counter increments each cycle.
  - ap_done=1 with ap_continue=1: run_count+1, last_latency := latency counter, go to IDLE.
  - If ap_start=1 in that same cycle, go to RUN instead with the latency counter reloaded to 1 (back-to-back runs).
  - ap_done=1 with ap_continue=0: go to HOLD. The latency counter stops.
- HOLD: wait for ap_continue=1, then apply the done actions above.
- busy=1 in RUN and HOLD, registered (visible 1 cycle after the edge).
- ap_done while IDLE: ignored, no count. ap_ready does not affect the state machine; it does not end a run.

Loop events, evaluated every cycle while busy or ap_start=1:
- start_ev = (cur_state==iter_start_state) & iter_start_enable & ~iter_start_block.
- end_ev = (cur_state==iter_end_state) & iter_end_enable & ~iter_end_block.
- iter_started+1 on start_ev; iter_completed+1 on end_ev. Both in the same cycle: both increment and in_flight is unchanged.
- in_flight is registered and never goes below 0. An end_ev with in_flight=0 still increments iter_completed, and in_flight stays 0.
- stall_cycles+1 on any cycle with busy=1 and (iter_start_block | iter_end_block) and cur_state equal to either configured state.
- loop_done is informational only; it does not modify any counter.

Arithmetic:
- All counters saturate at 2^CNT_W-1 and never wrap.
- last_latency saturates identically.

Finish:
- First cycle with finish=1: all counters freeze at their values after that edge; report_valid=1 from the next cycle.
- report_valid stays 1 until reset; later finish toggles have no effect.

Test Plan:
- Reset mid-run: ap_start pulse, 3 cycles, reset low -> all outputs 0 immediately, busy=0; after release, a fresh run counts from 1.
- Single run: ap_start at cycle 0, ap_done at cycle 9, continue=1 -> run_count=1, last_latency=10, busy=0 from cycle 11.
- Back-to-back: done and start coincide -> run_count=1 and busy stays 1; second run, 5 cycles -> run_count=2, last_latency=5.
- Continue hold: ap_done with ap_continue=0 for 4 cycles -> busy=1, run_count unchanged; continue=1 -> run_count increments and last_latency excludes the hold cycles.
- Pipeline counting, single state, depth 3:
  - 8 start events, then 8 end events each delayed 3 cycles -> iter_started=8, iter_completed=8, in_flight peaks at 3.
  - 2 blocked cycles -> stall_cycles=2 and no extra iterations.
- Finish and saturation, CNT_W=4:
  - 20 start events -> iter_started=15.
  - finish pulse, then further events -> counters unchanged, report_valid=1 one cycle after finish.
